// File: rtl/fast_corner_score.sv
// FAST-9 segment test and SAD corner score for both centres (p33, p43) of an
// 8x7 patch, three-stage pipeline, plus per-frame keypoint counting.
module fast_corner_score #(
    parameter int unsigned COL_NUM      = 640,
    parameter int unsigned ROW_NUM      = 480,
    parameter int unsigned PIXEL_WIDTH  = 8,
    parameter int unsigned KP_CNT_WIDTH = 16,
    localparam int unsigned XW = $clog2(COL_NUM),
    localparam int unsigned YW = $clog2(ROW_NUM),
    localparam int unsigned SW = PIXEL_WIDTH + 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PIXEL_WIDTH-1:0]  thresh,
    input  logic [PIXEL_WIDTH-1:0]  p00, p01, p02, p03, p04, p05, p06,
    input  logic [PIXEL_WIDTH-1:0]  p10, p11, p12, p13, p14, p15, p16,
    input  logic [PIXEL_WIDTH-1:0]  p20, p21, p22, p23, p24, p25, p26,
    input  logic [PIXEL_WIDTH-1:0]  p30, p31, p32, p33, p34, p35, p36,
    input  logic [PIXEL_WIDTH-1:0]  p40, p41, p42, p43, p44, p45, p46,
    input  logic [PIXEL_WIDTH-1:0]  p50, p51, p52, p53, p54, p55, p56,
    input  logic [PIXEL_WIDTH-1:0]  p60, p61, p62, p63, p64, p65, p66,
    input  logic [PIXEL_WIDTH-1:0]  p70, p71, p72, p73, p74, p75, p76,
    input  logic [XW-1:0]           x_coord,
    input  logic [YW-1:0]           y_coord,
    input  logic                    score_eol,
    input  logic                    patch8x7_valid,
    output logic [SW-1:0]           score0,
    output logic [SW-1:0]           score1,
    output logic                    corner0,
    output logic                    corner1,
    output logic [XW-1:0]           out_x,
    output logic [YW-1:0]           out_y,
    output logic                    out_eol,
    output logic                    out_vld,
    output logic                    frame_done,
    output logic [KP_CNT_WIDTH-1:0] kp_frame_count
);

    localparam int unsigned PW  = PIXEL_WIDTH;
    localparam int unsigned DW  = PW + 1;
    localparam int unsigned HW  = PW + 3;
    localparam int unsigned KW  = KP_CNT_WIDTH;
    localparam int unsigned KW1 = KW + 1;
    localparam int DR [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};
    localparam int DC [16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
    localparam logic [XW-1:0] X_LO  = XW'(3);
    localparam logic [XW-1:0] X_HI  = XW'(COL_NUM - 4);
    localparam logic [YW-1:0] Y_LO  = YW'(3);
    localparam logic [YW-1:0] Y_HI  = YW'(ROW_NUM - 4);
    localparam logic [YW-1:0] Y_END = YW'(ROW_NUM - 2);

    // 9 circularly contiguous set flags, wrap included via a doubled vector
    function automatic logic seg9(input logic [15:0] f);
        logic [31:0] ff;
        logic [31:0] sh;
        logic        hit;
        ff  = {f, f};
        hit = 1'b0;
        for (int s = 0; s < 16; s++) begin
            sh  = ff >> s;
            hit = hit | (&sh[8:0]);
        end
        return hit;
    endfunction

    function automatic logic [HW-1:0] sum8(input logic [8*PW-1:0] v);
        logic [HW-1:0] acc;
        acc = '0;
        for (int k = 0; k < 8; k++) acc = acc + HW'(v[k*PW +: PW]);
        return acc;
    endfunction

    logic [56*PW-1:0] pix;
    assign pix = {p76, p75, p74, p73, p72, p71, p70,
                  p66, p65, p64, p63, p62, p61, p60,
                  p56, p55, p54, p53, p52, p51, p50,
                  p46, p45, p44, p43, p42, p41, p40,
                  p36, p35, p34, p33, p32, p31, p30,
                  p26, p25, p24, p23, p22, p21, p20,
                  p16, p15, p14, p13, p12, p11, p10,
                  p06, p05, p04, p03, p02, p01, p00};

    // Threshold is live between frames and frozen from the first beat on
    logic          frame_active;
    logic [PW-1:0] thresh_r;
    logic [PW-1:0] t_c;
    logic [DW-1:0] t_ext;
    assign t_c   = frame_active ? thresh_r : thresh;
    assign t_ext = {1'b0, t_c};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_active <= 1'b0;
            thresh_r     <= '0;
        end else begin
            if (!frame_active) thresh_r <= thresh;
            if (patch8x7_valid && score_eol && (y_coord >= Y_END)) frame_active <= 1'b0;
            else if (patch8x7_valid) frame_active <= 1'b1;
        end
    end

    logic          s1_vld, s2_vld, s1_eol, s2_eol;
    logic [XW-1:0] s1_x, s2_x;
    logic [YW-1:0] s1_y, s2_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s2_vld  <= 1'b0;
            out_vld <= 1'b0;
            s1_eol  <= 1'b0;
            s2_eol  <= 1'b0;
            out_eol <= 1'b0;
            s1_x    <= '0;
            s2_x    <= '0;
            out_x   <= '0;
            s1_y    <= '0;
            s2_y    <= '0;
            out_y   <= '0;
        end else begin
            s1_vld  <= patch8x7_valid;
            s2_vld  <= s1_vld;
            out_vld <= s2_vld;
            if (patch8x7_valid) begin
                s1_eol <= score_eol;
                s1_x   <= x_coord;
                s1_y   <= y_coord;
            end
            if (s1_vld) begin
                s2_eol <= s1_eol;
                s2_x   <= s1_x;
                s2_y   <= s1_y;
            end
            if (s2_vld) begin
                out_eol <= s2_eol;
                out_x   <= s2_x;
                out_y   <= s2_y;
            end
        end
    end

    for (genvar w = 0; w < 2; w++) begin : g_win
        logic [DW-1:0]    cen;
        logic [15:0]      br, dk, s1_br, s1_dk;
        logic [16*PW-1:0] bd, dd, s1_bd, s1_dd;
        logic [HW-1:0]    bd_lo, bd_hi, dd_lo, dd_hi;
        logic             s2_corner, corner_c, inside_c, corner_q;
        logic [SW-1:0]    sum_bd_c, sum_dd_c, score_c, score_q;
        logic [YW-1:0]    yc;

        assign cen = {1'b0, pix[((3 + w) * 7 + 3) * PW +: PW]};

        for (genvar i = 0; i < 16; i++) begin : g_pt
            localparam int POS = (3 + w + DR[i]) * 7 + 3 + DC[i];
            logic [DW-1:0] cir, cen_t, cir_t;
            assign cir   = {1'b0, pix[POS * PW +: PW]};
            assign cen_t = cen + t_ext;
            assign cir_t = cir + t_ext;
            assign br[i] = cir > cen_t;
            assign dk[i] = cir_t < cen;
            assign bd[i*PW +: PW] = br[i] ? PW'(cir - cen_t) : '0;
            assign dd[i*PW +: PW] = dk[i] ? PW'(cen - cir_t) : '0;
        end

        assign corner_c = seg9(s1_br) | seg9(s1_dk);
        assign yc       = s2_y + YW'(w);
        assign inside_c = (s2_x >= X_LO) && (s2_x <= X_HI) && (yc >= Y_LO) && (yc <= Y_HI);
        assign sum_bd_c = SW'(bd_lo) + SW'(bd_hi);
        assign sum_dd_c = SW'(dd_lo) + SW'(dd_hi);
        assign score_c  = (s2_corner && inside_c) ?
                          ((sum_bd_c >= sum_dd_c) ? sum_bd_c : sum_dd_c) : '0;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1_br     <= '0;
                s1_dk     <= '0;
                s1_bd     <= '0;
                s1_dd     <= '0;
                s2_corner <= 1'b0;
                bd_lo     <= '0;
                bd_hi     <= '0;
                dd_lo     <= '0;
                dd_hi     <= '0;
                score_q   <= '0;
                corner_q  <= 1'b0;
            end else begin
                if (patch8x7_valid) begin
                    s1_br <= br;
                    s1_dk <= dk;
                    s1_bd <= bd;
                    s1_dd <= dd;
                end
                if (s1_vld) begin
                    s2_corner <= corner_c;
                    bd_lo     <= sum8(s1_bd[8*PW-1:0]);
                    bd_hi     <= sum8(s1_bd[16*PW-1:8*PW]);
                    dd_lo     <= sum8(s1_dd[8*PW-1:0]);
                    dd_hi     <= sum8(s1_dd[16*PW-1:8*PW]);
                end
                if (s2_vld) begin
                    score_q  <= score_c;
                    corner_q <= s2_corner && inside_c;
                end
            end
        end
    end

    assign score0  = g_win[0].score_q;
    assign score1  = g_win[1].score_q;
    assign corner0 = g_win[0].corner_q;
    assign corner1 = g_win[1].corner_q;

    // Saturating keypoint count, handed off when the frame's last beat leaves
    logic [KW-1:0] kp_cnt;
    logic [1:0]    inc_c;
    logic [KW:0]   kp_sum_c;
    logic [KW-1:0] kp_next_c;
    logic          frame_end_c;
    assign inc_c       = {1'b0, corner0} + {1'b0, corner1};
    assign kp_sum_c    = {1'b0, kp_cnt} + KW1'(inc_c);
    assign kp_next_c   = kp_sum_c[KW] ? '1 : kp_sum_c[KW-1:0];
    assign frame_end_c = out_vld && out_eol && (out_y >= Y_END);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kp_cnt         <= '0;
            kp_frame_count <= '0;
            frame_done     <= 1'b0;
        end else begin
            frame_done <= frame_end_c;
            if (frame_end_c) begin
                kp_frame_count <= kp_next_c;
                kp_cnt         <= '0;
            end else if (out_vld) begin
                kp_cnt <= kp_next_c;
            end
        end
    end

endmodule

// File: tb/tb_fast_corner_score.sv
// Directed bench for fast_corner_score: segment test, scores, borders,
// threshold latching, frame keypoint count and mid-frame reset.
module tb_fast_corner_score;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  thresh;
    logic [7:0]  px [8][7];
    logic [9:0]  x_coord;
    logic [8:0]  y_coord;
    logic        score_eol;
    logic        patch8x7_valid;
    logic [11:0] score0, score1;
    logic        corner0, corner1;
    logic [9:0]  out_x;
    logic [8:0]  out_y;
    logic        out_eol, out_vld, frame_done;
    logic [15:0] kp_frame_count;

    int checks = 0;
    int errors = 0;
    int fd_pulses = 0;
    int dr [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};
    int dc [16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};

    always #5 clk = ~clk;
    always @(negedge clk) if (frame_done) fd_pulses++;

    fast_corner_score dut (
        .clk(clk), .rst(rst), .thresh(thresh),
        .p00(px[0][0]), .p01(px[0][1]), .p02(px[0][2]), .p03(px[0][3]), .p04(px[0][4]), .p05(px[0][5]), .p06(px[0][6]),
        .p10(px[1][0]), .p11(px[1][1]), .p12(px[1][2]), .p13(px[1][3]), .p14(px[1][4]), .p15(px[1][5]), .p16(px[1][6]),
        .p20(px[2][0]), .p21(px[2][1]), .p22(px[2][2]), .p23(px[2][3]), .p24(px[2][4]), .p25(px[2][5]), .p26(px[2][6]),
        .p30(px[3][0]), .p31(px[3][1]), .p32(px[3][2]), .p33(px[3][3]), .p34(px[3][4]), .p35(px[3][5]), .p36(px[3][6]),
        .p40(px[4][0]), .p41(px[4][1]), .p42(px[4][2]), .p43(px[4][3]), .p44(px[4][4]), .p45(px[4][5]), .p46(px[4][6]),
        .p50(px[5][0]), .p51(px[5][1]), .p52(px[5][2]), .p53(px[5][3]), .p54(px[5][4]), .p55(px[5][5]), .p56(px[5][6]),
        .p60(px[6][0]), .p61(px[6][1]), .p62(px[6][2]), .p63(px[6][3]), .p64(px[6][4]), .p65(px[6][5]), .p66(px[6][6]),
        .p70(px[7][0]), .p71(px[7][1]), .p72(px[7][2]), .p73(px[7][3]), .p74(px[7][4]), .p75(px[7][5]), .p76(px[7][6]),
        .x_coord(x_coord), .y_coord(y_coord), .score_eol(score_eol), .patch8x7_valid(patch8x7_valid),
        .score0(score0), .score1(score1), .corner0(corner0), .corner1(corner1),
        .out_x(out_x), .out_y(out_y), .out_eol(out_eol), .out_vld(out_vld),
        .frame_done(frame_done), .kp_frame_count(kp_frame_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [7:0] v);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 7; c++) px[r][c] = v;
    endtask

    task automatic set0(input int idx, input logic [7:0] v);
        px[3 + dr[idx]][3 + dc[idx]] = v;
    endtask

    task automatic corner_both();
        fill(8'd200);
        px[3][3] = 8'd50;
        px[4][3] = 8'd50;
    endtask

    // Call right after a negedge, once the patch pixels are set
    task automatic drive(input int x, input int y, input int eol);
        x_coord        = 10'(x);
        y_coord        = 9'(y);
        score_eol      = 1'(eol);
        patch8x7_valid = 1'b1;
    endtask

    // Beat was driven at the current negedge; expect it three edges later
    task automatic expect_out(input string tag, input int c0, input int s0, input int c1,
                              input int s1, input int x, input int y, input int eol);
        @(negedge clk);
        patch8x7_valid = 1'b0;
        chk({tag, "_vld_n1"}, out_vld, 0);
        @(negedge clk);
        chk({tag, "_vld_n2"}, out_vld, 0);
        @(negedge clk);
        chk({tag, "_vld"}, out_vld, 1);
        chk({tag, "_c0"}, corner0, c0);
        chk({tag, "_s0"}, score0, s0);
        chk({tag, "_c1"}, corner1, c1);
        chk({tag, "_s1"}, score1, s1);
        chk({tag, "_x"}, out_x, x);
        chk({tag, "_y"}, out_y, y);
        chk({tag, "_eol"}, out_eol, eol);
    endtask

    task automatic expect_frame(input string tag, input int kp);
        @(negedge clk);
        chk({tag, "_done"}, frame_done, 1);
        chk({tag, "_kp"}, kp_frame_count, kp);
        @(negedge clk);
        chk({tag, "_done_clr"}, frame_done, 0);
    endtask

    initial begin
        int seen;
        int fd_before;
        rst = 1'b1;
        thresh = 8'd20;
        x_coord = '0;
        y_coord = '0;
        score_eol = 1'b0;
        patch8x7_valid = 1'b0;
        fill(8'd0);
        repeat (3) @(negedge clk);
        chk("rst_vld", out_vld, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_kp", kp_frame_count, 0);
        chk("rst_s0", score0, 0);
        chk("rst_c1", corner1, 0);
        rst = 1'b0;
        @(negedge clk);

        // Frame A, threshold 20 latched on the first beat
        fill(8'd100); drive(10, 10, 0);
        expect_out("flat", 0, 0, 0, 0, 10, 10, 0);
        @(negedge clk);
        fill(8'd50); for (int i = 0; i <= 8; i++) set0(i, 8'd100); drive(10, 10, 0);
        expect_out("run9", 1, 270, 0, 0, 10, 10, 0);
        @(negedge clk);
        fill(8'd50); for (int i = 12; i <= 20; i++) set0(i % 16, 8'd100); drive(11, 12, 0);
        expect_out("wrap9", 1, 270, 0, 0, 11, 12, 0);
        @(negedge clk);
        fill(8'd50); for (int i = 12; i <= 19; i++) set0(i % 16, 8'd100); drive(10, 10, 0);
        expect_out("wrap8", 0, 0, 0, 0, 10, 10, 0);
        @(negedge clk);
        corner_both(); drive(10, 10, 0);
        expect_out("both", 1, 2080, 1, 2080, 10, 10, 0);
        @(negedge clk);
        chk("hold_vld", out_vld, 0);
        chk("hold_s0", score0, 2080);
        thresh = 8'd100; corner_both(); drive(20, 30, 0);
        expect_out("latched", 1, 2080, 1, 2080, 20, 30, 0);
        @(negedge clk);
        corner_both(); drive(637, 10, 0);
        expect_out("x637", 0, 0, 0, 0, 637, 10, 0);
        @(negedge clk);
        corner_both(); drive(636, 3, 0);
        expect_out("x636y3", 1, 2080, 1, 2080, 636, 3, 0);
        @(negedge clk);
        corner_both(); drive(10, 476, 0);
        expect_out("y476", 1, 2080, 0, 0, 10, 476, 0);
        @(negedge clk);
        fill(8'd100); drive(636, 478, 1);
        expect_out("endA", 0, 0, 0, 0, 636, 478, 1);
        expect_frame("frameA", 9);

        // Frame B, live threshold 100 now latched
        @(negedge clk);
        corner_both(); drive(10, 10, 0);
        expect_out("t100", 1, 800, 1, 800, 10, 10, 0);
        @(negedge clk);
        fill(8'd100); drive(5, 478, 1);
        expect_out("endB", 0, 0, 0, 0, 5, 478, 1);
        expect_frame("frameB", 2);

        // Frame C, threshold 0, all-darker circle
        @(negedge clk);
        thresh = 8'd0; fill(8'd0); px[3][3] = 8'd255; drive(10, 10, 0);
        expect_out("dark", 1, 4080, 0, 0, 10, 10, 0);
        @(negedge clk);
        fill(8'd0); px[3][3] = 8'd255; drive(2, 10, 0);
        expect_out("dark_x2", 0, 0, 0, 0, 2, 10, 0);
        @(negedge clk);
        fill(8'd100); drive(9, 479, 1);
        expect_out("endC", 0, 0, 0, 0, 9, 479, 1);
        expect_frame("frameC", 1);

        // Frame D, back-to-back corner beats until the count saturates
        fd_before = fd_pulses;
        @(negedge clk);
        thresh = 8'd20; corner_both();
        for (int n = 0; n < 32800; n++) begin
            drive(10, 10, 0);
            @(negedge clk);
        end
        fill(8'd100); drive(10, 478, 1);
        @(negedge clk);
        patch8x7_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            @(negedge clk);
            if (frame_done) seen = 1;
        end
        chk("sat_done_seen", seen, 1);
        chk("sat_kp", kp_frame_count, 65535);
        repeat (5) @(negedge clk);
        chk("sat_pulses", fd_pulses - fd_before, 1);

        // Reset with a beat in flight
        @(negedge clk);
        corner_both(); drive(10, 10, 0);
        @(negedge clk);
        patch8x7_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("mrst_vld", out_vld, 0);
            chk("mrst_done", frame_done, 0);
        end
        chk("mrst_s0", score0, 0);
        chk("mrst_s1", score1, 0);
        chk("mrst_c0", corner0, 0);
        chk("mrst_c1", corner1, 0);
        chk("mrst_x", out_x, 0);
        chk("mrst_y", out_y, 0);
        chk("mrst_eol", out_eol, 0);
        chk("mrst_kp", kp_frame_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
